// File: rtl/vidout_pkg.sv
// Shared types and helpers for the clocked-video output engine:
// state encoding, raster totals, sync level mapping and a clog2 wrapper.
package vidout_pkg;

  typedef enum logic [1:0] {
    UNLOCKED   = 2'd0,
    WAIT_FRAME = 2'd1,
    RUN        = 2'd2
  } vid_state_e;

  function automatic int h_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  // Map a logical "sync asserted" onto the pin level for the chosen polarity.
  function automatic logic sync_level(logic asserted, bit active_high);
    return active_high ? asserted : ~asserted;
  endfunction

  function automatic int clog2(int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/vidout_sync_fifo.sv
// Single-clock show-ahead FIFO for {sop, eop, data} pixel entries.
// ready_o is registered and low throughout reset.
module vidout_sync_fifo
  import vidout_pkg::*;
#(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             ready_o
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      count_q, count_d;
  logic             full_s, push_s, pop_s, ready_q;

  assign full_s  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_s  = push_i & ~full_s;
  assign pop_s   = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_q];
  assign ready_o = ready_q;

  always_comb begin
    count_d = count_q;
    if (push_s && !pop_s) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - (AW+1)'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Ready tracks the next count so it equals (count < DEPTH) one cycle on.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push_s) wr_q <= wr_q + AW'(1);
      if (pop_s)  rd_q <= rd_q + AW'(1);
      count_q <= count_d;
      ready_q <= (count_d < (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_s) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/vidout_timing_engine.sv
// Clocked-video output engine: FIFO-buffered Avalon-ST pixels to raster video
// with frame lock on SOP/EOP. Optional colour bars via VIDOUT_TEST_PATTERN_EN.
module vidout_timing_engine
  import vidout_pkg::*;
#(
  parameter int H_ACTIVE          = 640,
  parameter int H_FP              = 16,
  parameter int H_SYNC            = 96,
  parameter int H_BP              = 48,
  parameter int V_ACTIVE          = 480,
  parameter int V_FP              = 10,
  parameter int V_SYNC            = 2,
  parameter int V_BP              = 33,
  parameter int BITS_PER_SYMBOL   = 8,
  parameter int SYMBOLS_PER_PIXEL = 3,
  parameter int FIFO_DEPTH        = 16,
  parameter int SYNC_ACTIVE_HIGH  = 0
) (
  input  logic                                         clk_clk,
  input  logic                                         reset_reset_n,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_PIXEL-1:0] din_data,
  input  logic                                         din_valid,
  output logic                                         din_ready,
  input  logic                                         din_sop,
  input  logic                                         din_eop,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_PIXEL-1:0] vid_data,
  output logic                                         vid_datavalid,
  output logic                                         vid_h_sync,
  output logic                                         vid_v_sync,
  output logic                                         vid_h,
  output logic                                         vid_v,
  output logic                                         vid_f,
  output logic                                         underflow,
  output logic                                         locked
);
  localparam int DW      = BITS_PER_SYMBOL * SYMBOLS_PER_PIXEL;
  localparam int HTOT    = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VTOT    = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = clog2(HTOT + 1);
  localparam int VW      = clog2(VTOT + 1);
  localparam bit SYNC_HI = (SYNC_ACTIVE_HIGH != 0);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  vid_state_e    state_q, state_d;
  logic          err_q, err_d, early_q, early_d;
  logic [DW+1:0] head_s;
  logic          fifo_empty_s, fifo_pop_s;
  logic          h_last_s, v_last_s, h_act_s, v_act_s, pix_act_s, pix_first_s, pix_last_s;
  logic          hs_act_s, vs_act_s, use_fill_s, uf_s;
  logic [DW-1:0] pix_s, fill_s, data_d;
  logic [DW-1:0] data_q;
  logic          dv_q, hb_q, vb_q, hs_q, vs_q, uf_q, locked_q;

  vidout_sync_fifo #(
    .WIDTH (DW + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_clk),
    .rst_ni  (reset_reset_n),
    .push_i  (din_valid & din_ready),
    .wdata_i ({din_sop, din_eop, din_data}),
    .pop_i   (fifo_pop_s),
    .head_o  (head_s),
    .empty_o (fifo_empty_s),
    .ready_o (din_ready)
  );

  assign h_last_s    = (h_q == HW'(HTOT - 1));
  assign v_last_s    = (v_q == VW'(VTOT - 1));
  assign h_act_s     = (h_q < HW'(H_ACTIVE));
  assign v_act_s     = (v_q < VW'(V_ACTIVE));
  assign pix_act_s   = h_act_s & v_act_s;
  assign pix_first_s = (h_q == '0) && (v_q == '0);
  assign pix_last_s  = (h_q == HW'(H_ACTIVE - 1)) && (v_q == VW'(V_ACTIVE - 1));
  assign hs_act_s    = (h_q >= HW'(H_ACTIVE + H_FP)) && (h_q < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_act_s    = (v_q >= VW'(V_ACTIVE + V_FP)) && (v_q < VW'(V_ACTIVE + V_FP + V_SYNC));

`ifdef VIDOUT_TEST_PATTERN_EN
  logic [2:0] bar_code_s;

  // Eight vertical bars; symbol s lights when bit (s mod 3) of the bar code is set.
  always_comb begin
    bar_code_s = 3'(7 - ((int'(h_q) * 8) / H_ACTIVE));
    fill_s     = '0;
    for (int s = 0; s < SYMBOLS_PER_PIXEL; s++) begin
      if (bar_code_s[s % 3]) fill_s[s*BITS_PER_SYMBOL +: BITS_PER_SYMBOL] = '1;
      else                   fill_s[s*BITS_PER_SYMBOL +: BITS_PER_SYMBOL] = '0;
    end
  end
`else
  assign fill_s = '0;
`endif

  always_comb begin
    h_d = h_last_s ? '0 : h_q + HW'(1);
    if (h_last_s) v_d = v_last_s ? '0 : v_q + VW'(1);
    else          v_d = v_q;
  end

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    early_d    = early_q;
    fifo_pop_s = 1'b0;
    uf_s       = 1'b0;
    use_fill_s = 1'b1;
    pix_s      = '0;
    case (state_q)
      UNLOCKED: begin
        if (!fifo_empty_s && head_s[DW+1]) state_d    = WAIT_FRAME;
        else                               fifo_pop_s = ~fifo_empty_s;
      end
      WAIT_FRAME: begin
        if (h_last_s && v_last_s) begin
          state_d = RUN;
          err_d   = 1'b0;
          early_d = 1'b0;
        end else begin
          state_d = WAIT_FRAME;
        end
      end
      RUN: begin
        use_fill_s = 1'b0;
        if (pix_act_s) begin
          if (early_q) begin
            pix_s = '0;
          end else if (fifo_empty_s) begin
            uf_s       = 1'b1;
            err_d      = 1'b1;
            use_fill_s = 1'b1;
          end else if (head_s[DW+1] && !pix_first_s) begin
            early_d = 1'b1;
          end else begin
            fifo_pop_s = 1'b1;
            pix_s      = head_s[DW-1:0];
          end
          // Frame verdict on the last active pixel; an early SOP is kept for the next frame.
          if (pix_last_s) begin
            if (early_d)                      state_d = WAIT_FRAME;
            else if (err_d || !head_s[DW])    state_d = UNLOCKED;
            else                              state_d = RUN;
            err_d   = 1'b0;
            early_d = 1'b0;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = UNLOCKED;
    endcase
    data_d = pix_act_s ? (use_fill_s ? fill_s : pix_s) : '0;
  end

  // Raster counters and frame-lock state.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      h_q     <= '0;
      v_q     <= '0;
      state_q <= UNLOCKED;
      err_q   <= 1'b0;
      early_q <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      state_q <= state_d;
      err_q   <= err_d;
      early_q <= early_d;
    end
  end

  // Output register stage: everything lags the counters by one clock.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      data_q   <= '0;
      dv_q     <= 1'b0;
      hb_q     <= 1'b0;
      vb_q     <= 1'b0;
      hs_q     <= sync_level(1'b0, SYNC_HI);
      vs_q     <= sync_level(1'b0, SYNC_HI);
      uf_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      dv_q     <= pix_act_s;
      hb_q     <= ~h_act_s;
      vb_q     <= ~v_act_s;
      hs_q     <= sync_level(hs_act_s, SYNC_HI);
      vs_q     <= sync_level(vs_act_s, SYNC_HI);
      uf_q     <= uf_s;
      locked_q <= (state_q == RUN);
    end
  end

  assign vid_data      = data_q;
  assign vid_datavalid = dv_q;
  assign vid_h_sync    = hs_q;
  assign vid_v_sync    = vs_q;
  assign vid_h         = hb_q;
  assign vid_v         = vb_q;
  assign vid_f         = 1'b0;
  assign underflow     = uf_q;
  assign locked        = locked_q;

endmodule

// File: doc/vidout_timing_engine.md
Name: vidout_timing_engine

Overview:
Parametrised clocked-video output engine. It converts an Avalon-ST pixel stream, buffered in an internal FIFO, into raster video with syncs, blanking flags and a data-valid strobe. It is the generalised successor of the fixed 24-bit VIP clocked-video output and drives the VGA/HDMI pins from the vga_clk domain. It adds configurable timing, pixel format and active-high or active-low sync polarity, plus frame lock/relock on SOP/EOP.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
BITS_PER_SYMBOL, 8, bits per colour plane
SYMBOLS_PER_PIXEL, 3, colour planes; DW = BITS_PER_SYMBOL*SYMBOLS_PER_PIXEL
FIFO_DEPTH, 16, pixel FIFO entries, power of two, >=4
SYNC_ACTIVE_HIGH, 0, 1 = syncs asserted high, 0 = asserted low

Ports:
clk_clk  in  1  pixel clock; all logic on rising edge
reset_reset_n  in  1  asynchronous active-low reset
din_data  in  DW  input pixel
din_valid  in  1  input beat valid
din_ready  out  1  input beat accepted when valid&ready
din_sop  in  1  first pixel of frame
din_eop  in  1  last pixel of frame
vid_data  out  DW  output pixel, 0 outside active region
vid_datavalid  out  1  active-region strobe
vid_h_sync  out  1  horizontal sync (polarity per SYNC_ACTIVE_HIGH)
vid_v_sync  out  1  vertical sync
vid_h  out  1  1 during horizontal blanking
vid_v  out  1  1 during vertical blanking
vid_f  out  1  field flag, tied 0 (progressive)
underflow  out  1  one-cycle pulse per active pixel with empty FIFO while RUN
locked  out  1  1 while state is RUN

Behaviour:
- One clock domain. Asynchronous active-low reset. All outputs are registered.
- Reset values: vid_data=0, vid_datavalid=0, vid_h=0, vid_v=0, syncs inactive, underflow=0, locked=0. din_ready is 0 while reset is asserted. FIFO is empty, counters are 0, state is UNLOCKED.
- Counters: h_cnt runs 0..H_TOTAL-1. v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1.
- Line order: active [0,H_ACTIVE), then FP, SYNC, BP. Frame order uses the same layout vertically.
- Outputs lag the counters by exactly 1 clock.
- vid_h_sync is asserted when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vid_v_sync uses the same rule on v_cnt, applied for whole lines.
- FIFO push/pop rules:
  - din_ready = (count < FIFO_DEPTH), computed from the registered count.
  - Each entry stores {sop, eop, data}.
  - A push and a pop in the same cycle leave count unchanged. A push while full is impossible because ready=0.
- State machine:
  - UNLOCKED: pop and discard the head every cycle while the head is non-sop. When the head is sop, go to WAIT_FRAME without popping.
  - WAIT_FRAME: hold the head. At h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, go to RUN. The next pixel is then frame pixel 0.
  - RUN, each active pixel:
    - Head valid and not sop (or sop on pixel 0): pop and output it.
    - FIFO empty: output 0 and pulse underflow.
    - Head is sop on any pixel other than 0 (early frame): do not pop, output 0 for the rest of the frame, then go to WAIT_FRAME at frame end.
  - RUN, last active pixel (x=H_ACTIVE-1, y=V_ACTIVE-1):
    - Popped entry has eop: stay in RUN.
    - Otherwise, or if any underflow occurred in the frame: go to UNLOCKED at the first blanking cycle.
- Outside RUN, the raster still runs with vid_data=0 and datavalid still asserted on active pixels.
- Reset asserted mid-frame: everything returns to reset values immediately.

Optional Feature:
- Macro VIDOUT_TEST_PATTERN_EN.
- Defined: while not in RUN, or on an underflow pixel, active pixels carry 8 vertical colour bars (bar index = h_cnt*8/H_ACTIVE). Bar i has each symbol s set to all-ones if bit (s mod 3) of (7-i) is set, else 0.
- Undefined: those pixels are 0.

Decomposition:
- Package vidout_pkg holds:
  - state enum {UNLOCKED, WAIT_FRAME, RUN}
  - localparam functions H_TOTAL/V_TOTAL
  - sync-level helper
  - clog2 wrapper
- Sub-module vidout_sync_fifo: single-clock FIFO, width DW+2, depth FIFO_DEPTH, with count, full, empty and show-ahead head.

Test Plan:
Small bench timing throughout: H 8/2/2/2 (total 14), V 4/1/1/1 (total 7), DW=24, FIFO_DEPTH=8.
- Reset released with no input: vid_h_sync low exactly at output cycles 10-11 of each 14-cycle line. vid_v_sync low for line 5. datavalid high 32 cycles per frame. locked=0.
- One full frame fed with values 1..32, sop on 1 and eop on 32: the next frame outputs 1..32 in raster order. locked=1. Zero underflow pulses.
- Input stalls after pixel 20: 12 underflow pulses, pixels 21-32 are 0, locked drops after that frame.
- A sop arrives at pixel 10 of a running frame: output is 0 from pixel 10 on. The following frame starts with the new sop pixel.
- Input held valid continuously while in WAIT_FRAME: din_ready falls after 8 accepted beats. No beat is lost or duplicated.
- SYNC_ACTIVE_HIGH=1: sync waveforms are the inverse of the first case. With VIDOUT_TEST_PATTERN_EN, an unlocked active pixel at x=0 is 0xFFFFFF and at x=7 is 0x000000.
